// File: rtl/counter_sequencer_pkg.sv
// Shared definitions for the counter sequencer: FSM state encoding and run modes.
package counter_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/counter_sequencer_if.sv
// Control/status bundle between the sequencer, its controller and the Counter datapath.
interface counter_sequencer_if #(
  parameter int WIDTH          = 5,
  parameter int PRESCALE_WIDTH = 8,
  parameter int WRAP_WIDTH     = 8
);
  logic                      start;
  logic                      stop;
  logic                      mode;
  logic [WIDTH-1:0]          terminal;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [WIDTH-1:0]          count;
  logic                      cnt_en;
  logic                      cnt_clr;
  logic                      busy;
  logic                      done;
  logic [WRAP_WIDTH-1:0]     wraps;

  modport slave (
    input  start, stop, mode, terminal, prescale, count,
    output cnt_en, cnt_clr, busy, done, wraps
  );

  modport master (
    output start, stop, mode, terminal, prescale, count,
    input  cnt_en, cnt_clr, busy, done, wraps
  );
endinterface

// File: rtl/counter_sequencer_tick_prescaler.sv
// Free-running modulo (prescale+1) tick generator, held at zero while clear is high.
module tick_prescaler #(
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] r_cnt;

  assign tick = !clear && (r_cnt == prescale);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clear || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Sequencer for the 5-bit Counter: clears it, paces increments from a prescaler tick,
// and stops or reloads at a latched terminal value. All outputs are registered.
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int WIDTH          = 5,
  parameter int PRESCALE_WIDTH = 8,
  parameter int WRAP_WIDTH     = 8
) (
  input  logic                clk,
  input  logic                reset,
  counter_sequencer_if.slave  bus
);

  state_e                    r_state, w_state_nxt;
  logic [WIDTH-1:0]          r_terminal;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic                      r_mode;
  logic                      r_cnt_en, r_cnt_clr, r_busy, r_done;
  logic [WRAP_WIDTH-1:0]     r_wraps;

  logic                      w_cnt_en_nxt, w_cnt_clr_nxt, w_busy_nxt, w_done_nxt;
  logic [WRAP_WIDTH-1:0]     w_wraps_nxt;
  logic                      w_latch;
  logic                      w_tick;
  logic [WIDTH-1:0]          w_count_eff;

  tick_prescaler #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .clear    (r_state != ST_RUN),
    .prescale (r_prescale),
    .tick     (w_tick)
  );

  // count lags our registered enable/clear by one edge; fold any in-flight action
  // in so back-to-back ticks compare against the value the counter is about to hold.
  always_comb begin
    w_count_eff = bus.count;
    if (r_cnt_clr) begin
      w_count_eff = '0;
    end else if (r_cnt_en) begin
      w_count_eff = bus.count + WIDTH'(1);
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_en_nxt  = 1'b0;
    w_cnt_clr_nxt = 1'b0;
    w_busy_nxt    = 1'b0;
    w_done_nxt    = 1'b0;
    w_wraps_nxt   = r_wraps;
    w_latch       = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.stop) begin
          w_state_nxt = ST_IDLE;
        end else if (bus.start) begin
          w_state_nxt   = ST_CLEAR;
          w_cnt_clr_nxt = 1'b1;
          w_busy_nxt    = 1'b1;
          w_wraps_nxt   = '0;
          w_latch       = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (bus.stop) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RUN;
          w_busy_nxt  = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_busy_nxt = 1'b1;
          if (w_tick) begin
            if (w_count_eff != r_terminal) begin
              w_cnt_en_nxt = 1'b1;
            end else begin
              w_done_nxt = 1'b1;
              if (r_mode == MODE_RELOAD) begin
                w_cnt_clr_nxt = 1'b1;
                w_wraps_nxt   = (&r_wraps) ? r_wraps : r_wraps + WRAP_WIDTH'(1);
              end else begin
                w_state_nxt = ST_DONE;
                w_busy_nxt  = 1'b0;
              end
            end
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_terminal <= '0;
      r_prescale <= '0;
      r_mode     <= MODE_ONESHOT;
      r_cnt_en   <= 1'b0;
      r_cnt_clr  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wraps    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt_en  <= w_cnt_en_nxt;
      r_cnt_clr <= w_cnt_clr_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_wraps   <= w_wraps_nxt;
      if (w_latch) begin
        r_terminal <= bus.terminal;
        r_prescale <= bus.prescale;
        r_mode     <= bus.mode;
      end
    end
  end

  assign bus.cnt_en  = r_cnt_en;
  assign bus.cnt_clr = r_cnt_clr;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.wraps   = r_wraps;

endmodule
